tdm_frame_demux: RTL and testbench
==================================

// Module: tdm_frame_demux
// PURPOSE
//   Receive side of the word-level time-division mux. Takes a serial stream of
//   W-bit words, one channel per valid beat, with channel 0 flagged by in_sof.
//   Assembles N_CH words into one frame, then presents all channels in
//   parallel with a one-cycle out_valid pulse. Sits between the link input
//   and per-channel consumers; flags malformed frames.
// PARAMETERS
//   N_CH   4   channels per frame; legal range 2..16
//   W      8   width of one channel word, in bits
// PORTS
//   clk        in   1        clock; all logic on posedge
//   rst        in   1        synchronous reset, active-high
//   in_valid   in   1        in_data/in_sof valid this cycle
//   in_sof     in   1        word is channel 0 (start of frame); ignored if !in_valid
//   in_data    in   W        channel word
//   out_valid  out  1        one-cycle pulse: out_data holds a new complete frame
//   out_data   out  N_CH*W   channel k in bits [k*W +: W]
//   out_err    out  1        one-cycle pulse: frame aborted (early sof)
//   out_busy   out  1        1 while a frame is partially collected (COLLECT)
// BEHAVIOUR
//   - Reset (rst=1 at posedge): state=HUNT, idx=0, shadow buffer=0,
//     out_data=0, out_valid=0, out_err=0, out_busy=0. Partial frame discarded.
//   - Registers: shadow buffer (N_CH*W), idx ($clog2(N_CH) bits),
//     state {HUNT, COLLECT}, and registered outputs.
//   - Cycles with in_valid=0: no state or idx change. Gaps of any length are
//     legal. out_valid and out_err are forced 0.
//   - HUNT:
//       valid & !sof -> word dropped, stay HUNT, no error.
//       valid & sof  -> shadow[0]=data, idx=1, go COLLECT.
//   - COLLECT (idx in 1..N_CH-1):
//       valid & !sof -> shadow[idx]=data.
//           If idx<N_CH-1: idx++.
//           If idx==N_CH-1: at the next posedge, out_data takes the shadow
//           buffer with the last word merged in. out_valid=1 for that one
//           cycle. idx=0, go HUNT.
//       valid & sof  -> early sof. The partial frame is discarded and out_err=1
//           for one cycle. The word is taken as a new channel 0:
//           shadow[0]=data, idx=1, stay COLLECT.
//           out_valid stays 0 and out_data is unchanged.
//   - Latency: the last word is accepted at edge t. out_valid and the new
//     out_data are visible after edge t, during cycle t+1.
//   - out_data holds its value between frames. It changes only on out_valid.
//   - Back-to-back frames: a sof arriving the cycle right after the last word
//     is accepted normally. HUNT is entered and left with no gap.
//   - out_valid and out_err are never both 1 in the same cycle.
//   - Stale shadow entries from an aborted frame are never output: every
//     entry 1..N_CH-1 is rewritten before completion.
//   - Mid-frame reset: no out_valid and no out_err is generated. After reset,
//     out_data=0.
//   - No backpressure. The consumer must sample out_data when out_valid=1.
// TESTING
//   1 Reset then a single frame, N_CH=4, W=8. Beats sof:11,22,33,44 on
//     consecutive cycles -> out_valid one cycle after 44; out_data=0x44332211;
//     out_err=0.
//   2 Gaps: same frame with 0-3 idle cycles between beats -> identical
//     out_data 0x44332211; exactly one out_valid pulse.
//   3 Words before sync: 0x55,0x66 without sof, then frame AA,BB,CC,DD with
//     sof on AA -> leading words dropped; out_data=0xDDCCBBAA; no out_err.
//   4 Early sof: sof:01,02, then sof:A1,B2,C3,D4 -> out_err pulse on the
//     cycle after A1; then out_valid with out_data=0xD4C3B2A1; exactly
//     1 err and 1 valid.
//   5 Back-to-back frames: 8 beats with no gap, frame 1 = 0x04030201,
//     frame 2 = 0x08070605 -> two out_valid pulses 4 cycles apart;
//     out_data holds 0x04030201 until the second pulse.
//   6 Reset mid-frame: sof:11,22 then rst=1 for one cycle, then a full
//     frame 0xA0B0C0D0 -> no valid/err pulses around reset;
//     out_data=0 until the new frame; out_busy=0 right after reset.

Source files
------------

// File: rtl/tdm_frame_demux.sv
// rtl/tdm_frame_demux.sv - word-level TDM receive side: serial channel words to parallel frames
// Flags frames cut short by an early start-of-frame.
module tdm_frame_demux #(
    parameter int N_CH = 4,
    parameter int W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                in_sof,
    input  logic [W-1:0]        in_data,
    output logic                out_valid,
    output logic [N_CH*W-1:0]   out_data,
    output logic                out_err,
    output logic                out_busy
);

    localparam int IDX_W = $clog2(N_CH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t                      state, state_n;
    logic [IDX_W-1:0]            idx, idx_n;
    logic [N_CH-1:0][W-1:0]      shadow, shadow_n;
    logic [N_CH*W-1:0]           data_n;
    logic                        valid_n;
    logic                        err_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            idx       <= '0;
            shadow    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            shadow    <= shadow_n;
            out_data  <= data_n;
            out_valid <= valid_n;
            out_err   <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        shadow_n = shadow;
        data_n   = out_data;
        valid_n  = 1'b0;
        err_n    = 1'b0;
        if (in_valid) begin
            case (state)
                HUNT: begin
                    // words seen before the first sof carry no channel alignment
                    if (in_sof) begin
                        shadow_n[0] = in_data;
                        idx_n       = ONE_IDX;
                        state_n     = COLLECT;
                    end
                end
                COLLECT: begin
                    if (in_sof) begin
                        // abort; stale entries get overwritten before the next completion
                        err_n       = 1'b1;
                        shadow_n[0] = in_data;
                        idx_n       = ONE_IDX;
                    end else begin
                        shadow_n[idx] = in_data;
                        if (idx == LAST_IDX) begin
                            data_n  = shadow_n;
                            valid_n = 1'b1;
                            idx_n   = '0;
                            state_n = HUNT;
                        end else begin
                            idx_n = idx + ONE_IDX;
                        end
                    end
                end
                default: begin
                    state_n = HUNT;
                    idx_n   = '0;
                end
            endcase
        end
    end

    assign out_busy = (state == COLLECT);

endmodule

// File: tb/tb_tdm_frame_demux.sv
// tb/tb_tdm_frame_demux.sv - self-checking bench for tdm_frame_demux against a queue-based frame model
module tb_tdm_frame_demux;

    localparam int N_CH = 4;
    localparam int W    = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_sof = 1'b0;
    logic [W-1:0]        in_data = '0;
    logic                out_valid;
    logic [N_CH*W-1:0]   out_data;
    logic                out_err;
    logic                out_busy;

    tdm_frame_demux #(.N_CH(N_CH), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_err   (out_err),
        .out_busy  (out_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;
    int n_err    = 0;

    // reference model: the words received since the last sof, held as a list
    logic [W-1:0]       m_words[$];
    bit                 m_in_frame = 1'b0;
    logic [N_CH*W-1:0]  m_data = '0;
    bit                 m_valid = 1'b0;
    bit                 m_err = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit v, input bit s, input logic [W-1:0] d);
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (r) begin
            m_words.delete();
            m_in_frame = 1'b0;
            m_data     = '0;
        end else if (v) begin
            if (s) begin
                m_err = m_in_frame;
                m_words.delete();
                m_words.push_back(d);
                m_in_frame = 1'b1;
            end else if (m_in_frame) begin
                m_words.push_back(d);
                if (m_words.size() == N_CH) begin
                    for (int k = 0; k < N_CH; k++)
                        m_data[k*W +: W] = m_words[k];
                    m_valid = 1'b1;
                    m_in_frame = 1'b0;
                    m_words.delete();
                end
            end
        end
    endtask

    task automatic cycle(input bit r, input bit v, input bit s, input logic [W-1:0] d);
        rst      = r;
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        @(posedge clk);
        model(r, v, s, d);
        #1;
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("out_err",   64'(out_err),   64'(m_err));
        check("out_busy",  64'(out_busy),  64'(m_in_frame));
        check("out_data",  64'(out_data),  64'(m_data));
        check("valid_err_excl", 64'(out_valid & out_err), 64'd0);
        if (out_valid) n_valid++;
        if (out_err)   n_err++;
    endtask

    task automatic beat(input bit s, input logic [W-1:0] d);
        cycle(1'b0, 1'b1, s, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic clear_counts();
        n_valid = 0;
        n_err   = 0;
    endtask

    initial begin
        // 1: reset, then a single frame on consecutive cycles
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        check("reset_data", 64'(out_data), 64'd0);
        check("reset_busy", 64'(out_busy), 64'd0);
        clear_counts();
        beat(1'b1, 8'h11); beat(1'b0, 8'h22); beat(1'b0, 8'h33); beat(1'b0, 8'h44);
        check("t1_valid_now", 64'(out_valid), 64'd1);
        check("t1_data", 64'(out_data), 64'h44332211);
        idle(2);
        check("t1_pulses", 64'(n_valid), 64'd1);
        check("t1_errs", 64'(n_err), 64'd0);

        // 2: same frame with random idle gaps
        clear_counts();
        beat(1'b1, 8'h11); idle($urandom_range(0, 3));
        beat(1'b0, 8'h22); idle($urandom_range(0, 3));
        beat(1'b0, 8'h33); idle($urandom_range(0, 3));
        beat(1'b0, 8'h44); idle(3);
        check("t2_data", 64'(out_data), 64'h44332211);
        check("t2_pulses", 64'(n_valid), 64'd1);

        // 3: words before sync are dropped
        clear_counts();
        beat(1'b0, 8'h55); beat(1'b0, 8'h66);
        check("t3_busy_hunt", 64'(out_busy), 64'd0);
        beat(1'b1, 8'hAA); beat(1'b0, 8'hBB); beat(1'b0, 8'hCC); beat(1'b0, 8'hDD);
        idle(1);
        check("t3_data", 64'(out_data), 64'hDDCCBBAA);
        check("t3_errs", 64'(n_err), 64'd0);

        // 4: early sof aborts the partial frame
        clear_counts();
        beat(1'b1, 8'h01); beat(1'b0, 8'h02);
        beat(1'b1, 8'hA1);
        check("t4_err_now", 64'(out_err), 64'd1);
        check("t4_data_held", 64'(out_data), 64'hDDCCBBAA);
        beat(1'b0, 8'hB2); beat(1'b0, 8'hC3); beat(1'b0, 8'hD4);
        idle(1);
        check("t4_data", 64'(out_data), 64'hD4C3B2A1);
        check("t4_pulses", 64'(n_valid), 64'd1);
        check("t4_errs", 64'(n_err), 64'd1);

        // 5: back-to-back frames with no gap
        clear_counts();
        beat(1'b1, 8'h01); beat(1'b0, 8'h02); beat(1'b0, 8'h03); beat(1'b0, 8'h04);
        check("t5_first", 64'(out_data), 64'h04030201);
        beat(1'b1, 8'h05); beat(1'b0, 8'h06); beat(1'b0, 8'h07);
        check("t5_hold", 64'(out_data), 64'h04030201);
        beat(1'b0, 8'h08);
        check("t5_second", 64'(out_data), 64'h08070605);
        check("t5_pulses", 64'(n_valid), 64'd2);

        // 6: reset in the middle of a frame
        clear_counts();
        beat(1'b1, 8'h11); beat(1'b0, 8'h22);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        check("t6_busy_after_rst", 64'(out_busy), 64'd0);
        check("t6_data_after_rst", 64'(out_data), 64'd0);
        beat(1'b1, 8'hD0); beat(1'b0, 8'hC0); beat(1'b0, 8'hB0);
        check("t6_data_pending", 64'(out_data), 64'd0);
        beat(1'b0, 8'hA0);
        check("t6_data", 64'(out_data), 64'hA0B0C0D0);
        check("t6_pulses", 64'(n_valid), 64'd1);
        check("t6_errs", 64'(n_err), 64'd0);

        // random traffic with gaps, stray sofs and occasional resets
        for (int i = 0; i < 3000; i++) begin
            bit r, v, s;
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 9) < 2);
            cycle(r, v, s, W'($urandom));
        end
        cycle(1'b0, 1'b0, 1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
